sid_pot_multi: RTL and testbench
================================

Name: sid_pot_multi

Overview:
- Multi-channel, parametrised successor of the single SID paddle/POT reader.
- Discharges all pot RC networks together, then times each channel's rise to logic-high within a fixed measurement window.
- Publishes all channel readings at once, with a valid strobe, at the end of each frame.
- Sits between the top-level IO cells and the SID register file (POTX/POTY and extra paddles); the top level owns the tristate IO cells, this block owns OE and sampling.

Parameters:
- CHANNELS, 2, number of independent pot inputs (1..8).
- DATA_W, 8, reading width; measurement window is 2**DATA_W CLKen ticks.
- DISCHARGE_TICKS, 256, CLKen ticks per frame with pins driven low (>=1).
- SYNC_STAGES, 2, input synchroniser depth (>=2).

Ports:
- CLK  in  1  system clock.
- RESETn  in  1  asynchronous active-low reset.
- CLKen  in  1  phi2 tick enable; all timing counts these ticks.
- ENABLE  in  1  frame engine run; low holds block in discharge.
- POT_IN  in  CHANNELS  raw pin levels from IO cells, bit i = channel i.
- POT_OE  out  CHANNELS  1 = IO cell drives pin to ground.
- DATA  out  CHANNELS*DATA_W  readings; channel i at [i*DATA_W +: DATA_W].
- VALID  out  1  one-CLK pulse when DATA updates.
- TIMEOUT  out  CHANNELS  per-channel flag, 1 = channel never rose last frame.

Behaviour:
- Reset values: state DISCHARGE, tick counter 0, POT_OE all 1, DATA 0, VALID 0, TIMEOUT 0, captured flags 0, synchronisers 0.
- POT_IN passes through SYNC_STAGES flops per bit before any use.
- States:
  - DISCHARGE: POT_OE all 1.
    - Counter increments on CLKen.
    - On the CLKen where counter == DISCHARGE_TICKS-1 and ENABLE=1: counter <= 0, clear captured flags, go to MEASURE.
  - MEASURE: POT_OE all 0.
    - Counter m (DATA_W bits) increments on CLKen.
    - Any CLK where channel i's synced input = 1 and its captured flag = 0: capture[i] <= m, set flag. Capture happens on any CLK, not only CLKen.
    - On the CLKen where m == 2**DATA_W-1: go to PUBLISH.
    - Channel i rising on that same CLK is captured with value 2**DATA_W-1 and TIMEOUT[i]=0.
  - PUBLISH: exactly one CLK.
    - DATA[i] <= capture[i] if flagged, else all-ones with TIMEOUT[i] <= 1; flagged channels get TIMEOUT[i] <= 0.
    - VALID=1 this CLK only; counter <= 0; go to DISCHARGE.
- Output timing: POT_OE changes take effect on the CLK after the state transition (registered).
- Input already high at measure start: captured at m=0.
- Capture latency: input edge to capture is SYNC_STAGES CLKs; reading is the m value current at capture.
- ENABLE=0 in MEASURE:
  - Abort to DISCHARGE next CLK, counter 0, POT_OE all 1.
  - No PUBLISH, DATA/TIMEOUT hold.
- ENABLE=0 in DISCHARGE: counter keeps running but saturates at DISCHARGE_TICKS-1; MEASURE is entered on the first CLKen after ENABLE returns.
- CLKen low indefinitely: counters freeze; captures still occur in MEASURE.
- RESETn asserted mid-frame: immediate return to reset values, pins driven low.
- DATA updates only in PUBLISH; all channels update on the same CLK.

Optional Feature:
- Macro SID_POT_FILTER_EN.
- Defined: PUBLISH writes DATA[i] <= (DATA[i] + new[i] + 1) >> 1, with a DATA_W+1 intermediate and round-half-up.
  - Timeout samples are filtered as the value all-ones.
  - The first frame after reset loads new[i] directly, tracked by a first-frame flag.
  - TIMEOUT always reflects the raw, unfiltered frame.
- Not defined: DATA[i] <= new[i]; no filter registers synthesised.

Test Plan:
Bench setup: CHANNELS=2, DATA_W=8, DISCHARGE_TICKS=256, CLKen every 4 CLK.
- Reset then ENABLE=1, hold POT_IN=0 -> POT_OE=2'b11 for 256 ticks then 2'b00; after 256 measure ticks, VALID pulse, DATA={8'hFF,8'hFF}, TIMEOUT=2'b11.
- Ch0 rises at measure tick 37, ch1 at tick 200 -> DATA[7:0]=37, DATA[15:8]=200, TIMEOUT=2'b00, exactly one VALID per frame.
- POT_IN=2'b11 throughout -> both channels read 0; ch0 rising on the final tick (255) -> reads 255 with TIMEOUT[0]=0.
- ENABLE dropped at measure tick 100 -> POT_OE=2'b11 next CLK, no VALID, DATA unchanged; re-enable -> full 256-tick discharge before the next MEASURE.
- RESETn pulsed low at measure tick 50 -> asynchronous return: POT_OE=2'b11, DATA=0, VALID=0 within the same cycle.
- SID_POT_FILTER_EN: frame readings 100 then 201 -> DATA=100, then 151.

Source files
------------

// File: rtl/sid_pot_multi.sv
// Multi-channel SID paddle reader: discharge all pots, time each rise over a 2**DATA_W tick window, publish together.
// Optional SID_POT_FILTER_EN averages each new reading with the previous one (round-half-up).
module sid_pot_multi #(
  parameter int CHANNELS        = 2,
  parameter int DATA_W          = 8,
  parameter int DISCHARGE_TICKS = 256,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                       CLK,
  input  logic                       RESETn,
  input  logic                       CLKen,
  input  logic                       ENABLE,
  input  logic [CHANNELS-1:0]        POT_IN,
  output logic [CHANNELS-1:0]        POT_OE,
  output logic [CHANNELS*DATA_W-1:0] DATA,
  output logic                       VALID,
  output logic [CHANNELS-1:0]        TIMEOUT
);

  localparam int DIS_W = $clog2(DISCHARGE_TICKS + 1);
  localparam int CNT_W = (DIS_W > DATA_W) ? DIS_W : DATA_W;
  localparam logic [CNT_W-1:0] DIS_LAST  = CNT_W'(DISCHARGE_TICKS - 1);
  localparam logic [CNT_W-1:0] MEAS_LAST = CNT_W'({DATA_W{1'b1}});

  typedef enum logic [1:0] {
    S_DISCHARGE,
    S_MEASURE,
    S_PUBLISH
  } state_t;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [CHANNELS-1:0]       sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0]       pot_s;
  logic [CHANNELS-1:0]       flag_q;
  logic [DATA_W-1:0]         cap_q [CHANNELS];
  logic [DATA_W-1:0]         new_val;
  logic [CHANNELS*DATA_W-1:0] next_data;
`ifdef SID_POT_FILTER_EN
  logic                      first_q;
  logic [DATA_W:0]           avg;
`endif

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= POT_IN;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign pot_s = sync_q[SYNC_STAGES-1];

  // Uncaptured channels report all-ones; the filter treats them as that value too.
  always_comb begin
    next_data = '0;
    new_val   = '0;
`ifdef SID_POT_FILTER_EN
    avg       = '0;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      new_val = flag_q[i] ? cap_q[i] : {DATA_W{1'b1}};
`ifdef SID_POT_FILTER_EN
      avg = {1'b0, DATA[i*DATA_W +: DATA_W]} + {1'b0, new_val} + {{DATA_W{1'b0}}, 1'b1};
      next_data[i*DATA_W +: DATA_W] = first_q ? new_val : avg[DATA_W:1];
`else
      next_data[i*DATA_W +: DATA_W] = new_val;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state   <= S_DISCHARGE;
      cnt     <= '0;
      POT_OE  <= '1;
      DATA    <= '0;
      VALID   <= 1'b0;
      TIMEOUT <= '0;
      flag_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) cap_q[i] <= '0;
`ifdef SID_POT_FILTER_EN
      first_q <= 1'b1;
`endif
    end else begin
      VALID <= 1'b0;
      case (state)
        S_DISCHARGE: begin
          POT_OE <= '1;
          // Counter parks at the last tick while disabled so measurement starts promptly on re-enable.
          if (CLKen) begin
            if (cnt >= DIS_LAST) begin
              if (ENABLE) begin
                cnt    <= '0;
                flag_q <= '0;
                POT_OE <= '0;
                state  <= S_MEASURE;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_MEASURE: begin
          if (!ENABLE) begin
            cnt    <= '0;
            POT_OE <= '1;
            state  <= S_DISCHARGE;
          end else begin
            for (int i = 0; i < CHANNELS; i++) begin
              if (pot_s[i] && !flag_q[i]) begin
                cap_q[i]  <= cnt[DATA_W-1:0];
                flag_q[i] <= 1'b1;
              end
            end
            if (CLKen) begin
              if (cnt == MEAS_LAST) state <= S_PUBLISH;
              else                  cnt   <= cnt + CNT_W'(1);
            end
          end
        end
        S_PUBLISH: begin
          DATA    <= next_data;
          TIMEOUT <= ~flag_q;
          VALID   <= 1'b1;
          cnt     <= '0;
          POT_OE  <= '1;
          state   <= S_DISCHARGE;
`ifdef SID_POT_FILTER_EN
          first_q <= 1'b0;
`endif
        end
        default: begin
          cnt    <= '0;
          POT_OE <= '1;
          state  <= S_DISCHARGE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sid_pot_multi.sv
// Bench for sid_pot_multi: directed frames, expected readings queued per frame and checked on VALID.
// Expected values follow SID_POT_FILTER_EN when that macro is defined.
module tb_sid_pot_multi;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        CLKen = 1'b0;
  logic [1:0]  div = 2'd0;
  logic        ENABLE;
  logic [1:0]  POT_IN;
  logic [1:0]  POT_OE;
  logic [15:0] DATA;
  logic        VALID;
  logic [1:0]  TIMEOUT;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  t;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] last_d = 16'h0000;

  sid_pot_multi #(
    .CHANNELS(2), .DATA_W(8), .DISCHARGE_TICKS(256), .SYNC_STAGES(2)
  ) dut (
    .CLK(CLK), .RESETn(RESETn), .CLKen(CLKen), .ENABLE(ENABLE),
    .POT_IN(POT_IN), .POT_OE(POT_OE), .DATA(DATA), .VALID(VALID), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  // One CLKen every 4 CLKs, changed just after the rising edge.
  always @(posedge CLK) begin
    #1;
    div   = div + 2'd1;
    CLKen = (div == 2'd0);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Counts CLKen ticks until POT_OE reaches lvl; called and returns at a negedge.
  task automatic wait_oe(input logic [1:0] lvl, output int ticks);
    int c;
    ticks = 0;
    c = 0;
    while (POT_OE !== lvl && c < 3000) begin
      if (CLKen) ticks++;
      c++;
      @(negedge CLK);
    end
    if (POT_OE !== lvl) begin
      n_cmp++;
      n_bad++;
      $display("FAIL oe_wait: POT_OE=%b expected %b", POT_OE, lvl);
    end
  endtask

  // r < 0: channel never rises; r == 0: high throughout; else rises so capture lands on tick r.
  task automatic run_frame(input int r0, input int r1,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [1:0] et);
    int   ticks;
    logic done;
    POT_IN[0] = (r0 == 0);
    POT_IN[1] = (r1 == 0);
    wait_oe(2'b00, ticks);
    check("discharge_ticks", 32'(ticks), 32'd256);
    sbq.push_back({e1, e0, et});
    last_d = {e1, e0};
    ticks = 0;
    done  = 1'b0;
    for (int c = 0; c < 1100 && !done; c++) begin
      if (r0 > 0 && c == 4*r0 + 1) POT_IN[0] = 1'b1;
      if (r1 > 0 && c == 4*r1 + 1) POT_IN[1] = 1'b1;
      if (VALID === 1'b1) done = 1'b1;
      else begin
        if (CLKen) ticks++;
        @(negedge CLK);
      end
    end
    check("valid_seen", 32'(done), 32'd1);
    check("measure_ticks", 32'(ticks), 32'd256);
    check("oe_after_publish", 32'(POT_OE), 32'h3);
    POT_IN = 2'b00;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (VALID === 1'b1) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: DATA=%h TIMEOUT=%b", DATA, TIMEOUT);
        end else begin
          e = sbq.pop_front();
          check("data", 32'(DATA), 32'(e.d));
          check("timeout", 32'(TIMEOUT), 32'(e.t));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int ticks;
    RESETn = 1'b0;
    ENABLE = 1'b0;
    POT_IN = 2'b00;
    repeat (3) @(negedge CLK);
    check("rst_oe", 32'(POT_OE), 32'h3);
    check("rst_data", 32'(DATA), 32'h0);
    check("rst_valid", 32'(VALID), 32'h0);
    check("rst_timeout", 32'(TIMEOUT), 32'h0);
    RESETn = 1'b1;
    ENABLE = 1'b1;

`ifdef SID_POT_FILTER_EN
    run_frame(-1, -1, 8'd255, 8'd255, 2'b11);
    run_frame(37, 200, 8'd146, 8'd228, 2'b00);
    run_frame(0, 0, 8'd73, 8'd114, 2'b00);
    run_frame(255, -1, 8'd164, 8'd185, 2'b10);
`else
    run_frame(-1, -1, 8'd255, 8'd255, 2'b11);
    run_frame(37, 200, 8'd37, 8'd200, 2'b00);
    run_frame(0, 0, 8'd0, 8'd0, 2'b00);
    run_frame(255, -1, 8'd255, 8'd255, 2'b10);
`endif

    // Abort at measure tick 100.
    wait_oe(2'b00, ticks);
    check("abort_discharge_ticks", 32'(ticks), 32'd256);
    repeat (400) @(negedge CLK);
    ENABLE = 1'b0;
    @(negedge CLK);
    check("abort_oe", 32'(POT_OE), 32'h3);
    check("abort_valid", 32'(VALID), 32'h0);
    check("abort_data_hold", 32'(DATA), 32'(last_d));
    @(negedge CLK);
    ENABLE = 1'b1;
`ifdef SID_POT_FILTER_EN
    run_frame(10, 20, 8'd87, 8'd103, 2'b00);
`else
    run_frame(10, 20, 8'd10, 8'd20, 2'b00);
`endif

    // Asynchronous reset at measure tick 50.
    wait_oe(2'b00, ticks);
    check("pre_reset_discharge_ticks", 32'(ticks), 32'd256);
    repeat (200) @(negedge CLK);
    #2;
    RESETn = 1'b0;
    #1;
    check("async_rst_oe", 32'(POT_OE), 32'h3);
    check("async_rst_data", 32'(DATA), 32'h0);
    check("async_rst_valid", 32'(VALID), 32'h0);
    check("async_rst_timeout", 32'(TIMEOUT), 32'h0);
    @(negedge CLK);
    RESETn = 1'b1;

`ifdef SID_POT_FILTER_EN
    run_frame(100, -1, 8'd100, 8'd255, 2'b10);
    run_frame(201, -1, 8'd151, 8'd255, 2'b10);
`else
    run_frame(100, -1, 8'd100, 8'd255, 2'b10);
    run_frame(201, -1, 8'd201, 8'd255, 2'b10);
`endif

    repeat (4) @(negedge CLK);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
